etb_tim_trig_router: RTL and testbench

//   APB-programmable event-trigger router sitting directly upstream of the timer block.

---
 rtl/etb_trig_pkg.sv | 40 ++++
 rtl/etb_trig_chan.sv | 96 +++++++++
 rtl/etb_tim_trig_router.sv | 125 ++++++++++++
 tb/tb_etb_tim_trig_router.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/etb_trig_pkg.sv
// Shared definitions for the timer event-trigger router: register offsets,
// CHCFG field layout, edge-mode and action encodings.
// Optional per-channel fire counters are enabled with ETB_TRIG_EVT_CNT_EN.
package etb_trig_pkg;

  // Register offsets (byte addresses)
  localparam logic [7:0] AddrCtrl      = 8'h00;
  localparam logic [7:0] AddrSwtrig    = 8'h04;
  localparam logic [7:0] AddrStatus    = 8'h08;
  localparam logic [7:0] AddrChcfgBase = 8'h10;
  localparam logic [7:0] AddrCntBase   = 8'h40;

  // CHCFG field positions and widths
  localparam int unsigned CfgEnBit   = 0;
  localparam int unsigned CfgActBit  = 1;
  localparam int unsigned CfgEdgeLsb = 2;
  localparam int unsigned CfgEdgeW   = 2;
  localparam int unsigned CfgSrcLsb  = 8;
  localparam int unsigned CfgSrcW    = 4;
  localparam int unsigned CfgDstLsb  = 16;
  localparam int unsigned CfgDstW    = 4;

  typedef enum logic [1:0] {
    EdgeRise = 2'b00,
    EdgeFall = 2'b01,
    EdgeBoth = 2'b10,
    EdgeNone = 2'b11
  } edge_mode_e;

  typedef enum logic {
    ActOn  = 1'b0,
    ActOff = 1'b1
  } act_e;

  // Address of the per-channel register c in a bank starting at base
  function automatic logic [7:0] chan_addr(logic [7:0] base, int c);
    return base + 8'(c * 4);
  endfunction

endpackage

// File: rtl/etb_trig_chan.sv
// One routing channel: holds its CHCFG, selects a source bit, matches the
// configured edge, checks SRC/DST range and raises fire for one cycle.
// With ETB_TRIG_EVT_CNT_EN defined it also keeps an 8-bit saturating counter.
module etb_trig_chan
  import etb_trig_pkg::*;
#(
  parameter int unsigned SrcNum = 8,
  parameter int unsigned DstNum = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we_i,
  input  logic        cnt_we_i,
  input  logic [31:0] wdata_i,
  input  logic [15:0] src_cur_i,
  input  logic [15:0] src_prev_i,
  input  logic        gen_i,
  input  logic        sw_i,
  output logic        fire_o,
  output logic        act_o,
  output logic [3:0]  dst_o,
  output logic [31:0] cfg_o,
  output logic [7:0]  cnt_o
);

  logic       en_q;
  act_e       act_q;
  edge_mode_e edge_sel_q;
  logic [3:0] src_sel_q;
  logic [3:0] dst_q;

  // CHCFG register; only defined fields are stored
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q       <= 1'b0;
      act_q      <= ActOn;
      edge_sel_q <= EdgeRise;
      src_sel_q  <= '0;
      dst_q      <= '0;
    end else if (cfg_we_i) begin
      en_q       <= wdata_i[CfgEnBit];
      act_q      <= act_e'(wdata_i[CfgActBit]);
      edge_sel_q <= edge_mode_e'(wdata_i[CfgEdgeLsb +: CfgEdgeW]);
      src_sel_q  <= wdata_i[CfgSrcLsb +: CfgSrcW];
      dst_q      <= wdata_i[CfgDstLsb +: CfgDstW];
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^{wdata_i[31:20], wdata_i[15:12], wdata_i[7:4]};

  logic cur, prev, edge_hit, in_range;

  // Edge match on the selected source and range qualification
  always_comb begin
    cur      = src_cur_i[src_sel_q];
    prev     = src_prev_i[src_sel_q];
    edge_hit = 1'b0;
    unique case (edge_sel_q)
      EdgeRise: edge_hit = cur & ~prev;
      EdgeFall: edge_hit = ~cur & prev;
      EdgeBoth: edge_hit = cur ^ prev;
      default:  edge_hit = 1'b0;
    endcase
    in_range = (32'(src_sel_q) < SrcNum) && (32'(dst_q) < DstNum);
  end

  assign fire_o = gen_i & en_q & in_range & (edge_hit | sw_i);
  assign act_o  = (act_q == ActOff);
  assign dst_o  = dst_q;
  assign cfg_o  = {12'd0, dst_q, 4'd0, src_sel_q, 4'd0, edge_sel_q, act_q, en_q};

`ifdef ETB_TRIG_EVT_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturating fire count; a write clears it and beats a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    if (fire_o && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    if (cnt_we_i) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`else
  logic unused_cnt_we;
  assign unused_cnt_we = cnt_we_i;
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/etb_tim_trig_router.sv
// APB-programmable event-trigger router feeding the timer on/off enables.
// Top level: APB decode, CTRL/STATUS, source history, per-channel routing
// and the registered on/off output stage (off beats on for the same dst).
// Optional per-channel fire counters (0x40+4c) are enabled with ETB_TRIG_EVT_CNT_EN.
module etb_tim_trig_router
  import etb_trig_pkg::*;
#(
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned SRC_NUM = 8,
  parameter int unsigned DST_NUM = 2
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [7:0]         paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  input  logic [SRC_NUM-1:0] src_trig,
  output logic [DST_NUM-1:0] dst_trig_on,
  output logic [DST_NUM-1:0] dst_trig_off
);

  logic wr, rd;
  assign wr = psel & penable & pwrite;
  assign rd = psel & penable & ~pwrite;

  logic               gen_q, gen_d;
  logic [CH_NUM-1:0]  status_q, status_d;
  logic [SRC_NUM-1:0] src_q, src_q2;
  logic [DST_NUM-1:0] on_q, on_d, off_q, off_d;

  logic [CH_NUM-1:0]  sw_vec, w1c_vec;
  logic [CH_NUM-1:0]  fire, act, cfg_we, cnt_we;
  logic [3:0]         dst    [CH_NUM];
  logic [31:0]        cfg_rd [CH_NUM];
  logic [7:0]         cnt_rd [CH_NUM];
  logic [15:0]        src_cur, src_prev;

  // Zero-pad history so any 4-bit SRC index is in bounds
  assign src_cur  = 16'(src_q);
  assign src_prev = 16'(src_q2);

  assign sw_vec  = (wr && (paddr == AddrSwtrig)) ? pwdata[CH_NUM-1:0] : '0;
  assign w1c_vec = (wr && (paddr == AddrStatus)) ? pwdata[CH_NUM-1:0] : '0;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
    assign cfg_we[c] = wr && (paddr == chan_addr(AddrChcfgBase, c));
    assign cnt_we[c] = wr && (paddr == chan_addr(AddrCntBase, c));

    etb_trig_chan #(
      .SrcNum (SRC_NUM),
      .DstNum (DST_NUM)
    ) u_chan (
      .clk_i      (pclk),
      .rst_i      (preset),
      .cfg_we_i   (cfg_we[c]),
      .cnt_we_i   (cnt_we[c]),
      .wdata_i    (pwdata),
      .src_cur_i  (src_cur),
      .src_prev_i (src_prev),
      .gen_i      (gen_q),
      .sw_i       (sw_vec[c]),
      .fire_o     (fire[c]),
      .act_o      (act[c]),
      .dst_o      (dst[c]),
      .cfg_o      (cfg_rd[c]),
      .cnt_o      (cnt_rd[c])
    );
  end

  // Next-state for CTRL, STATUS (set beats W1C) and the output OR/priority stage
  always_comb begin
    gen_d    = (wr && (paddr == AddrCtrl)) ? pwdata[0] : gen_q;
    status_d = (status_q & ~w1c_vec) | fire;
    on_d     = '0;
    off_d    = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      for (int d = 0; d < DST_NUM; d++) begin
        if (fire[c] && (dst[c] == 4'(d))) begin
          if (act[c]) off_d[d] = 1'b1;
          else        on_d[d]  = 1'b1;
        end
      end
    end
    on_d = on_d & ~off_d;
  end

  // State registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      gen_q    <= 1'b0;
      status_q <= '0;
      src_q    <= '0;
      src_q2   <= '0;
      on_q     <= '0;
      off_q    <= '0;
    end else begin
      gen_q    <= gen_d;
      status_q <= status_d;
      src_q    <= src_trig;
      src_q2   <= src_q;
      on_q     <= on_d;
      off_q    <= off_d;
    end
  end

  assign dst_trig_on  = on_q;
  assign dst_trig_off = off_q;

  // APB read mux; undefined offsets and SWTRIG read as zero
  always_comb begin
    prdata = '0;
    if (rd) begin
      if (paddr == AddrCtrl)   prdata = {31'd0, gen_q};
      if (paddr == AddrStatus) prdata = 32'(status_q);
      for (int c = 0; c < CH_NUM; c++) begin
        if (paddr == chan_addr(AddrChcfgBase, c)) prdata = cfg_rd[c];
        if (paddr == chan_addr(AddrCntBase, c))   prdata = 32'(cnt_rd[c]);
      end
    end
  end

endmodule

// File: tb/tb_etb_tim_trig_router.sv
// Self-checking bench for etb_tim_trig_router: a cycle-level behavioural model
// checked every cycle plus directed scenarios with literal expectations.
// Honours ETB_TRIG_EVT_CNT_EN when defined for the build.
`timescale 1ns/1ps
module tb_etb_tim_trig_router;

  localparam int unsigned CH  = 4;
  localparam int unsigned SRC = 8;
  localparam int unsigned DST = 2;

  logic           pclk    = 1'b0;
  logic           preset  = 1'b0;
  logic           psel    = 1'b0;
  logic           penable = 1'b0;
  logic           pwrite  = 1'b0;
  logic [7:0]     paddr   = '0;
  logic [31:0]    pwdata  = '0;
  logic [31:0]    prdata;
  logic [SRC-1:0] src_trig = '0;
  logic [DST-1:0] dst_trig_on, dst_trig_off;

  etb_tim_trig_router #(
    .CH_NUM  (CH),
    .SRC_NUM (SRC),
    .DST_NUM (DST)
  ) dut (
    .pclk         (pclk),
    .preset       (preset),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .src_trig     (src_trig),
    .dst_trig_on  (dst_trig_on),
    .dst_trig_off (dst_trig_off)
  );

  always #5 pclk = ~pclk;

  // ---------------- behavioural model ----------------
  // Output after edge k is derived from the source samples taken at edges
  // k-1 and k-2, the configuration written before edge k and a SWTRIG
  // write completing at edge k.
  logic [31:0]    m_cfg [CH];
  logic           m_gen;
  logic [SRC-1:0] m_p1, m_p2;
  logic [DST-1:0] m_on, m_off;
  logic [CH-1:0]  m_status;
  int unsigned    m_cnt [CH];

  always @(posedge pclk or posedge preset) begin : model
    logic [CH-1:0]  fire;
    logic [DST-1:0] on_n, off_n;
    logic [15:0]    p1x, p2x;
    logic           wr, hit, rise, fall;
    int unsigned    s, d, e;
    if (preset) begin
      for (int c = 0; c < CH; c++) begin
        m_cfg[c] <= '0;
        m_cnt[c] <= 0;
      end
      m_gen    <= 1'b0;
      m_p1     <= '0;
      m_p2     <= '0;
      m_on     <= '0;
      m_off    <= '0;
      m_status <= '0;
    end else begin
      wr    = psel && penable && pwrite;
      p1x   = 16'(m_p1);
      p2x   = 16'(m_p2);
      fire  = '0;
      on_n  = '0;
      off_n = '0;
      for (int c = 0; c < CH; c++) begin
        s    = (m_cfg[c] >> 8) & 32'hF;
        d    = (m_cfg[c] >> 16) & 32'hF;
        e    = (m_cfg[c] >> 2) & 32'h3;
        rise = p1x[s] && !p2x[s];
        fall = !p1x[s] && p2x[s];
        hit  = wr && (paddr == 8'h04) && pwdata[c];
        if (e == 0 && rise) hit = 1'b1;
        if (e == 1 && fall) hit = 1'b1;
        if (e == 2 && (rise || fall)) hit = 1'b1;
        if (m_gen && m_cfg[c][0] && s < SRC && d < DST && hit) begin
          fire[c] = 1'b1;
          if (m_cfg[c][1]) off_n[d] = 1'b1;
          else             on_n[d]  = 1'b1;
        end
      end
      m_on  <= on_n & ~off_n;
      m_off <= off_n;
      if (wr && paddr == 8'h08) m_status <= (m_status & ~pwdata[CH-1:0]) | fire;
      else                      m_status <= m_status | fire;
      if (wr && paddr == 8'h00) m_gen <= pwdata[0];
      for (int c = 0; c < CH; c++) begin
        if (wr && paddr == 8'(16 + 4 * c)) m_cfg[c] <= pwdata & 32'h000F_0F0F;
`ifdef ETB_TRIG_EVT_CNT_EN
        if (wr && paddr == 8'(64 + 4 * c))      m_cnt[c] <= 0;
        else if (fire[c] && m_cnt[c] < 255)     m_cnt[c] <= m_cnt[c] + 1;
`endif
      end
      m_p2 <= m_p1;
      m_p1 <= src_trig;
    end
  end

  // ---------------- bookkeeping ----------------
  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int on_cnt  [DST];
  int off_cnt [DST];
  int on_first  [DST];
  int off_first [DST];
  int off_last  [DST];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon_clear();
    for (int d = 0; d < DST; d++) begin
      on_cnt[d]    = 0;
      off_cnt[d]   = 0;
      on_first[d]  = -1;
      off_first[d] = -1;
      off_last[d]  = -1;
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Write completes at the second edge; returns 1ns after it
  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    #2;
    d = prdata;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    apb_rd(a, v);
    check(name, v, exp);
  endtask

  function automatic int total_pulses();
    int t = 0;
    for (int d = 0; d < DST; d++) t += on_cnt[d] + off_cnt[d];
    return t;
  endfunction

  // ---------------- stimulus and checking ----------------
  initial begin : main
    int t0;
    mon_clear();
    fork
      forever begin
        @(posedge pclk);
        cyc++;
      end
      forever begin
        @(negedge pclk);
        check("model_on", 32'(dst_trig_on), 32'(m_on));
        check("model_off", 32'(dst_trig_off), 32'(m_off));
        for (int d = 0; d < DST; d++) begin
          if (dst_trig_on[d] === 1'b1) begin
            if (on_cnt[d] == 0) on_first[d] = cyc;
            on_cnt[d]++;
          end
          if (dst_trig_off[d] === 1'b1) begin
            if (off_cnt[d] == 0) off_first[d] = cyc;
            off_last[d] = cyc;
            off_cnt[d]++;
          end
        end
      end
    join_none

    #1 preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    // Reset state
    check("rst_on", 32'(dst_trig_on), 32'd0);
    check("rst_off", 32'(dst_trig_off), 32'd0);
    check("rst_prdata_idle", prdata, 32'd0);
    rd_chk("rst_ctrl", 8'h00, 32'd0);
    rd_chk("rst_status", 8'h08, 32'd0);
    rd_chk("rst_chcfg0", 8'h10, 32'd0);

    // 1: rise on src0 held 10 cycles -> single on[0] pulse
    apb_wr(8'h10, 32'h0000_0001);
    apb_wr(8'h00, 32'h1);
    mon_clear();
    src_trig[0] = 1'b1;
    t0 = cyc;
    tick_n(10);
    src_trig[0] = 1'b0;
    tick_n(4);
    check("t1_on_count", 32'(on_cnt[0]), 32'd1);
    check("t1_latency", 32'(on_first[0] - t0), 32'd2);
    check("t1_other_pulses", 32'(total_pulses() - on_cnt[0]), 32'd0);
    rd_chk("t1_status", 8'h08, 32'h1);

    // 2: both-edge on src3 -> two off[1] pulses 4 cycles apart
    apb_wr(8'h08, 32'h1);
    apb_wr(8'h14, 32'h0001_030B);
    mon_clear();
    src_trig[3] = 1'b1;
    tick_n(4);
    src_trig[3] = 1'b0;
    tick_n(5);
    check("t2_off_count", 32'(off_cnt[1]), 32'd2);
    check("t2_off_spacing", 32'(off_last[1] - off_first[1]), 32'd4);
    check("t2_on_none", 32'(on_cnt[0] + on_cnt[1]), 32'd0);
    rd_chk("t2_status", 8'h08, 32'h2);

    // 3: on and off to dst0 in the same cycle -> off wins
    apb_wr(8'h14, 32'h0);
    apb_wr(8'h10, 32'h0000_0101);
    apb_wr(8'h18, 32'h0000_0103);
    apb_wr(8'h08, 32'hF);
    mon_clear();
    src_trig[1] = 1'b1;
    tick_n(2);
    src_trig[1] = 1'b0;
    tick_n(4);
    check("t3_off0", 32'(off_cnt[0]), 32'd1);
    check("t3_on0_suppressed", 32'(on_cnt[0]), 32'd0);
    rd_chk("t3_status", 8'h08, 32'h5);

    // 4: software trigger, then blocked by GEN=0
    apb_wr(8'h10, 32'h0);
    apb_wr(8'h18, 32'h0);
    apb_wr(8'h14, 32'h0001_000D);
    apb_wr(8'h08, 32'hF);
    apb_wr(8'h04, 32'h2);
    check("t4_sw_pulse", 32'(dst_trig_on), 32'h2);
    tick();
    check("t4_sw_one_cycle", 32'(dst_trig_on), 32'h0);
    rd_chk("t4_status", 8'h08, 32'h2);
    rd_chk("t4_swtrig_reads0", 8'h04, 32'h0);
    apb_wr(8'h08, 32'hF);
    apb_wr(8'h00, 32'h0);
    mon_clear();
    apb_wr(8'h04, 32'h2);
    tick_n(2);
    check("t4_gen0_no_pulse", 32'(total_pulses()), 32'd0);
    rd_chk("t4_gen0_status", 8'h08, 32'h0);
    apb_wr(8'h00, 32'h1);

    // 5: out-of-range SRC / DST never fire
    apb_wr(8'h14, 32'h0);
    apb_wr(8'h1C, 32'h0000_0F01);
    mon_clear();
    src_trig = '1;
    tick_n(3);
    src_trig = '0;
    tick_n(4);
    check("t5_src_oor", 32'(total_pulses()), 32'd0);
    rd_chk("t5_src_oor_status", 8'h08, 32'h0);
    apb_wr(8'h1C, 32'h0005_0001);
    mon_clear();
    src_trig[0] = 1'b1;
    tick_n(3);
    src_trig[0] = 1'b0;
    apb_wr(8'h04, 32'h8);
    tick_n(4);
    check("t5_dst_oor", 32'(total_pulses()), 32'd0);
    rd_chk("t5_dst_oor_status", 8'h08, 32'h0);
    apb_wr(8'h1C, 32'hFFFF_FFFF);
    rd_chk("t5_chcfg_mask", 8'h1C, 32'h000F_0F0F);
    apb_wr(8'h1C, 32'h0);
    apb_wr(8'h0C, 32'hFFFF_FFFF);
    rd_chk("t5_undef_reads0", 8'h0C, 32'h0);
    // W1C on the same edge as a new fire: set wins
    apb_wr(8'h10, 32'h0000_0001);
    apb_wr(8'h04, 32'h1);
    rd_chk("t5_pre_status", 8'h08, 32'h1);
    tick_n(3);
    src_trig[0] = 1'b1;
    apb_wr(8'h08, 32'h1);
    rd_chk("t5_set_wins", 8'h08, 32'h1);
    src_trig[0] = 1'b0;
    tick_n(3);
    apb_wr(8'h08, 32'h1);
    rd_chk("t5_w1c_clears", 8'h08, 32'h0);

    // 6: counters (when built in) and asynchronous reset
`ifdef ETB_TRIG_EVT_CNT_EN
    rd_chk("t6_cnt1", 8'h44, 32'd3);
    for (int i = 0; i < 300; i++) apb_wr(8'h04, 32'h1);
    rd_chk("t6_cnt0_sat", 8'h40, 32'hFF);
    apb_wr(8'h40, 32'h0);
    rd_chk("t6_cnt0_clear", 8'h40, 32'h0);
`else
    for (int i = 0; i < 3; i++) apb_wr(8'h04, 32'h1);
    rd_chk("t6_cnt_absent", 8'h40, 32'h0);
`endif
    apb_wr(8'h04, 32'h1);
    check("t6_pulse_before_rst", 32'(dst_trig_on), 32'h1);
    #1 preset = 1'b1;
    #1;
    check("t6_rst_on_async", 32'(dst_trig_on), 32'h0);
    check("t6_rst_off_async", 32'(dst_trig_off), 32'h0);
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    rd_chk("t6_rst_ctrl", 8'h00, 32'h0);
    rd_chk("t6_rst_chcfg0", 8'h10, 32'h0);
    rd_chk("t6_rst_status", 8'h08, 32'h0);
    rd_chk("t6_rst_cnt0", 8'h40, 32'h0);
    mon_clear();
    src_trig[0] = 1'b1;
    tick_n(4);
    src_trig[0] = 1'b0;
    check("t6_no_fire_after_rst", 32'(total_pulses()), 32'd0);
    tick_n(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
